multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control FSM that sequences a multicycle MIPS datapath: one shared instruction/data memory, one ALU, instruction register. Decodes `op`/`funct` and issues per-cycle mux selects, write enables and ALU control. Stalls on a memory-ready handshake. Counts retired instructions. Sits beside the datapath and memory port, replacing the combinational main/ALU decoders of the single-cycle core.

## Interface
- `MEM_HANDSHAKE`, 1: 1 = memory states wait for `mem_ready`; 0 = `mem_ready` ignored, treated as 1.
- `CNT_W`, 32: width of the retired-instruction counter.

- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: instruction[31:26] from the instruction register.
- `funct` in 6: instruction[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `memreq` out 1: memory access requested.
- `memwrite` out 1: memory write strobe.
- `iord` out 1: 0 = address from PC, 1 = address from ALU out register.
- `irwrite` out 1: load the instruction register.
- `pcen` out 1: PC write enable = `pcwrite | (branch & zero)`.
- `regwrite` out 1: register-file write.
- `regdst` out 1: 1 = rd, 0 = rt.
- `memtoreg` out 1: 1 = data register, 0 = ALU out.
- `alusrca` out 1: 0 = PC, 1 = rs.
- `alusrcb` out 2: 00 = rt, 01 = 4, 10 = signimm, 11 = signimm<<2.
- `pcsrc` out 2: 00 = ALU result, 01 = ALU out register, 10 = jump target.
- `alucontrol` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal` out 1: one-cycle pulse on an undecodable instruction.
- `state` out 4: current state code, for debug.
- `instret` out CNT_W: count of retired instructions.

## Operation
- Outputs are Moore-decoded from `state`, except `pcen` (needs `zero`) and the `mem_ready` gating.
- Every output not listed for a state is 0. Default `alucontrol` is 010.
- States, their codes and assertions:
  - FETCH(0): `memreq`, `iord`=0, `alusrca`=0, `alusrcb`=01, add, `pcsrc`=00. `irwrite` and `pcwrite` are asserted only when `mem_ready`. Stays in FETCH until `mem_ready`, then goes to DECODE.
  - DECODE(1): `alusrca`=0, `alusrcb`=11, add (precomputes the branch target). Next state by `op`:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 (R-type) → EXECUTE
    - 000100 (beq) → BRANCH
    - 001000 (addi) → ADDIEX
    - 000010 (j) → JUMP
    - anything else → FETCH with `illegal`=1.
  - R-type with `funct` not in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt} is also illegal → FETCH.
  - MEMADR(2): `alusrca`=1, `alusrcb`=10, add. → MEMRD for lw, → MEMWR for sw.
  - MEMRD(3): `memreq`, `iord`=1. Holds until `mem_ready`, then → MEMWB.
  - MEMWB(4): `regwrite`, `regdst`=0, `memtoreg`=1. → FETCH.
  - MEMWR(5): `memreq`, `iord`=1, `memwrite`. Holds until `mem_ready`, then → FETCH.
  - EXECUTE(6): `alusrca`=1, `alusrcb`=00, `alucontrol` from `funct` (add 010, sub 110, and 000, or 001, slt 111). → ALUWB.
  - ALUWB(7): `regwrite`, `regdst`=1, `memtoreg`=0. → FETCH.
  - BRANCH(8): `alusrca`=1, `alusrcb`=00, sub, `pcsrc`=01, branch=1, so `pcen`=`zero`. → FETCH.
  - ADDIEX(9): `alusrca`=1, `alusrcb`=10, add. → ADDIWB.
  - ADDIWB(10): `regwrite`, `regdst`=0, `memtoreg`=0. → FETCH.
  - JUMP(11): `pcsrc`=10, `pcwrite`. → JUMP goes to FETCH.
- Codes 12–15 are unreachable. If entered, go to FETCH next cycle.
- Retirement: `instret` increments by 1 on the edge leaving MEMWB, MEMWR (on `mem_ready`), ALUWB, BRANCH, ADDIWB or JUMP. Illegal instructions do not retire. The counter wraps from 2^CNT_W−1 to 0.
- `mem_ready` is sampled only in FETCH, MEMRD and MEMWR. In all other states it is ignored.

## Timing
- Reset, sampled on a rising edge:
  - Next state is FETCH and `instret`=0.
  - While `reset` is high, `memreq`, `memwrite`, `irwrite`, `pcen`, `regwrite` and `illegal` are forced to 0.
- Reset asserted mid-instruction abandons it with no further writes. FETCH begins the cycle after `reset` falls.
- Cycles with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each cycle `mem_ready` is low in a memory state adds 1 cycle.
- `memreq` stays high and address selects stay stable for as long as a state waits. The memory must not see `memwrite` drop before `mem_ready`.
- `pcen` in BRANCH follows `zero` combinationally in the same cycle.

## Test plan
- Reset then `mem_ready`=1, `op`=100011 → states 0,1,2,3,4,0. `regwrite`=1 only in state 4. `instret`=1 after 5 cycles.
- sw with `mem_ready` low for 3 cycles in MEMWR → `memwrite`=`memreq`=1 held for 4 cycles. `instret` increments once, on the ready cycle.
- beq with `zero`=1 then `zero`=0 → `pcen`=1, `pcsrc`=01 in BRANCH for the first; `pcen`=0 for the second. 3 cycles each.
- R-type with `funct`=101010 → `alucontrol`=111 in EXECUTE, `regdst`=1 in ALUWB. `funct`=000111 → `illegal` pulse in DECODE, back to FETCH, `instret` unchanged.
- `op`=111111 → `illegal`=1 for one cycle, then FETCH. j → `pcsrc`=10, `pcen`=1, 3 cycles.
- `reset` asserted in MEMRD → next cycle is FETCH with `instret`=0. With `MEM_HANDSHAKE`=0 and `mem_ready` tied to 0, lw still takes 5 cycles.

Source files
------------

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for a multicycle MIPS datapath with a single shared
// instruction/data memory, one ALU and an instruction register. Each
// instruction is walked through FETCH -> DECODE -> (class-specific states)
// -> FETCH. The FSM issues per-cycle mux selects, write enables and ALU
// control, stalls memory states on a ready handshake and counts retired
// instructions.
//
// Parameters
//   MEM_HANDSHAKE : 1 = memory states wait for mem_ready, 0 = mem_ready ignored
//   CNT_W         : width of the retired-instruction counter
//
// Ports
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   op, funct     : instruction fields from the instruction register
//   zero          : ALU zero flag (branch condition)
//   mem_ready     : memory completes the current access this cycle
//   memreq        : memory access request
//   memwrite      : memory write strobe
//   iord          : memory address select (0 = PC, 1 = ALU out register)
//   irwrite       : instruction register load
//   pcen          : PC write enable (pcwrite | branch & zero)
//   regwrite      : register-file write
//   regdst        : write register select (1 = rd, 0 = rt)
//   memtoreg      : write-back data select (1 = data register, 0 = ALU out)
//   alusrca       : ALU A select (0 = PC, 1 = rs)
//   alusrcb       : ALU B select (00 rt, 01 4, 10 signimm, 11 signimm<<2)
//   pcsrc         : PC source (00 ALU result, 01 ALU out reg, 10 jump target)
//   alucontrol    : ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   illegal       : one-cycle pulse in DECODE on an undecodable instruction
//   state         : current state code, for debug
//   instret       : retired-instruction count, wraps
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter logic MEM_HANDSHAKE = 1'b1,
    parameter int   CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             memreq,
    output logic             memwrite,
    output logic             iord,
    output logic             irwrite,
    output logic             pcen,
    output logic             regwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    // State codes are externally visible on the debug port, so they are fixed.
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_instret;

    logic             w_rdy;
    logic             w_funct_ok;
    logic [2:0]       w_alu_funct;
    logic             w_decode_ok;
    logic [3:0]       w_decode_next;
    logic [3:0]       w_next;
    logic             w_retire;

    // Raw (pre-reset-gating) control outputs.
    logic             w_memreq;
    logic             w_memwrite;
    logic             w_irwrite;
    logic             w_pcwrite;
    logic             w_branch;
    logic             w_regwrite;
    logic             w_illegal;

    // With the handshake disabled every memory access completes in one cycle.
    assign w_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // R-type function decode: legality and ALU operation.
    always_comb begin
        w_funct_ok  = 1'b1;
        w_alu_funct = ALU_ADD;
        case (funct)
            FN_ADD:  w_alu_funct = ALU_ADD;
            FN_SUB:  w_alu_funct = ALU_SUB;
            FN_AND:  w_alu_funct = ALU_AND;
            FN_OR:   w_alu_funct = ALU_OR;
            FN_SLT:  w_alu_funct = ALU_SLT;
            default: w_funct_ok  = 1'b0;
        endcase
    end

    // Opcode decode for the DECODE state's successor.
    always_comb begin
        w_decode_ok   = 1'b1;
        w_decode_next = S_FETCH;
        case (op)
            OP_LW, OP_SW: w_decode_next = S_MEMADR;
            OP_RTYPE: begin
                if (w_funct_ok) w_decode_next = S_EXECUTE;
                else            w_decode_ok   = 1'b0;
            end
            OP_BEQ:  w_decode_next = S_BRANCH;
            OP_ADDI: w_decode_next = S_ADDIEX;
            OP_J:    w_decode_next = S_JUMP;
            default: w_decode_ok   = 1'b0;
        endcase
    end

    // Next-state logic. Unused codes 12..15 fall back to FETCH.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = w_rdy ? S_DECODE : S_FETCH;
            S_DECODE:  w_next = w_decode_next;
            S_MEMADR: begin
                if (op == OP_LW)      w_next = S_MEMRD;
                else if (op == OP_SW) w_next = S_MEMWR;
                else                  w_next = S_FETCH;
            end
            S_MEMRD:   w_next = w_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = w_rdy ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next = S_ALUWB;
            S_ALUWB:   w_next = S_FETCH;
            S_BRANCH:  w_next = S_FETCH;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_ADDIWB:  w_next = S_FETCH;
            S_JUMP:    w_next = S_FETCH;
            default:   w_next = S_FETCH;
        endcase
    end

    // An instruction retires on the edge leaving its final state; a store
    // only retires once the memory has accepted the write.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: w_retire = 1'b1;
            S_MEMWR: w_retire = w_rdy;
            default: w_retire = 1'b0;
        endcase
    end

    // Moore output decode; mem_ready gates only the FETCH-side writes.
    always_comb begin
        w_memreq   = 1'b0;
        w_memwrite = 1'b0;
        iord       = 1'b0;
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_regwrite = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        w_illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_memreq  = 1'b1;
                alusrcb   = 2'b01;
                w_irwrite = w_rdy;
                w_pcwrite = w_rdy;
            end
            S_DECODE: begin
                alusrcb   = 2'b11;
                w_illegal = ~w_decode_ok;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                w_memreq = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                memtoreg   = 1'b1;
            end
            S_MEMWR: begin
                w_memreq   = 1'b1;
                w_memwrite = 1'b1;
                iord       = 1'b1;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = w_alu_funct;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                regdst     = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                w_branch   = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Side-effecting strobes are held off while reset is high so an
    // abandoned instruction cannot write anything.
    assign memreq   = w_memreq   & ~reset;
    assign memwrite = w_memwrite & ~reset;
    assign irwrite  = w_irwrite  & ~reset;
    assign regwrite = w_regwrite & ~reset;
    assign illegal  = w_illegal  & ~reset;
    assign pcen     = (w_pcwrite | (w_branch & zero)) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_instret <= r_instret + CNT_ONE;
        end
    end

    assign state   = r_state;
    assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    // Bit positions in the packed observation vector.
    localparam int B_MEMREQ = 16, B_MEMWRITE = 15, B_IORD = 14, B_IRWRITE = 13;
    localparam int B_REGWRITE = 12, B_REGDST = 11, B_MEMTOREG = 10, B_PCEN = 9;
    localparam int B_ILLEGAL = 8, B_ALUSRCA = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, rst_nh, zero, mem_ready;
    logic [5:0] op, funct;

    logic        memreq, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg;
    logic        alusrca, illegal;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic [3:0]  state;
    logic [31:0] instret;

    logic        nh_memreq, nh_memwrite, nh_iord, nh_irwrite, nh_pcen, nh_regwrite;
    logic        nh_regdst, nh_memtoreg, nh_alusrca, nh_illegal;
    logic [1:0]  nh_alusrcb, nh_pcsrc;
    logic [2:0]  nh_alucontrol;
    logic [3:0]  nh_state;
    logic [2:0]  nh_instret;

    multicycle_controller #(.MEM_HANDSHAKE(1'b1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .memreq(memreq), .memwrite(memwrite), .iord(iord),
        .irwrite(irwrite), .pcen(pcen), .regwrite(regwrite), .regdst(regdst),
        .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .illegal(illegal), .state(state), .instret(instret)
    );

    // Handshake disabled, ready tied low, narrow counter to reach the wrap.
    multicycle_controller #(.MEM_HANDSHAKE(1'b0), .CNT_W(3)) dut_nh (
        .clk(clk), .reset(rst_nh), .op(op), .funct(funct), .zero(zero),
        .mem_ready(1'b0), .memreq(nh_memreq), .memwrite(nh_memwrite), .iord(nh_iord),
        .irwrite(nh_irwrite), .pcen(nh_pcen), .regwrite(nh_regwrite), .regdst(nh_regdst),
        .memtoreg(nh_memtoreg), .alusrca(nh_alusrca), .alusrcb(nh_alusrcb),
        .pcsrc(nh_pcsrc), .alucontrol(nh_alucontrol), .illegal(nh_illegal),
        .state(nh_state), .instret(nh_instret)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] e_instret = '0;
    logic [3:0]  exp_st[$];
    logic        exp_rdy[$];
    logic [3:0]  obs_st[$];
    logic [16:0] obs_vec[$];
    logic [31:0] obs_ir[$];
    logic [3:0]  end_st;
    logic [31:0] end_ir;
    logic        end_ill;

    // ---------------- reference model ----------------
    function automatic bit is_legal(input logic [5:0] o, input logic [5:0] f);
        if (o == OP_RT)
            return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        return o inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected control outputs for a state, straight from the state table.
    function automatic logic [16:0] exp_out(input logic [3:0] st, input logic rdy,
                                            input logic z, input logic [5:0] f, input bit legal);
        logic [16:0] v;
        v = '0;
        v[4:2] = 3'b010;
        case (st)
            4'd0:  begin v[B_MEMREQ] = 1'b1; v[B_IRWRITE] = rdy; v[B_PCEN] = rdy; v[6:5] = 2'b01; end
            4'd1:  begin v[6:5] = 2'b11; v[B_ILLEGAL] = !legal; end
            4'd2:  begin v[B_ALUSRCA] = 1'b1; v[6:5] = 2'b10; end
            4'd3:  begin v[B_MEMREQ] = 1'b1; v[B_IORD] = 1'b1; end
            4'd4:  begin v[B_REGWRITE] = 1'b1; v[B_MEMTOREG] = 1'b1; end
            4'd5:  begin v[B_MEMREQ] = 1'b1; v[B_IORD] = 1'b1; v[B_MEMWRITE] = 1'b1; end
            4'd6:  begin v[B_ALUSRCA] = 1'b1; v[4:2] = alu_of(f); end
            4'd7:  begin v[B_REGWRITE] = 1'b1; v[B_REGDST] = 1'b1; end
            4'd8:  begin v[B_ALUSRCA] = 1'b1; v[4:2] = 3'b110; v[1:0] = 2'b01; v[B_PCEN] = z; end
            4'd9:  begin v[B_ALUSRCA] = 1'b1; v[6:5] = 2'b10; end
            4'd10: v[B_REGWRITE] = 1'b1;
            4'd11: begin v[1:0] = 2'b10; v[B_PCEN] = 1'b1; end
            default: ;
        endcase
        return v;
    endfunction

    task automatic push_c(input logic [3:0] s, input logic r);
        exp_st.push_back(s);
        exp_rdy.push_back(r);
    endtask

    // Expected state walk of one instruction plus the mem_ready drive pattern:
    // wf stall cycles in FETCH, wm stall cycles in the data-memory state.
    // Outside memory states mem_ready is random (it must be ignored there).
    task automatic build_seq(input logic [5:0] o, input logic [5:0] f, input int wf, input int wm);
        exp_st.delete();
        exp_rdy.delete();
        repeat (wf) push_c(4'd0, 1'b0);
        push_c(4'd0, 1'b1);
        push_c(4'd1, 1'($urandom_range(0, 1)));
        if (is_legal(o, f)) begin
            case (o)
                OP_LW: begin
                    push_c(4'd2, 1'($urandom_range(0, 1)));
                    repeat (wm) push_c(4'd3, 1'b0);
                    push_c(4'd3, 1'b1);
                    push_c(4'd4, 1'($urandom_range(0, 1)));
                end
                OP_SW: begin
                    push_c(4'd2, 1'($urandom_range(0, 1)));
                    repeat (wm) push_c(4'd5, 1'b0);
                    push_c(4'd5, 1'b1);
                end
                OP_RT: begin
                    push_c(4'd6, 1'($urandom_range(0, 1)));
                    push_c(4'd7, 1'($urandom_range(0, 1)));
                end
                OP_BEQ:  push_c(4'd8, 1'($urandom_range(0, 1)));
                OP_ADDI: begin
                    push_c(4'd9, 1'($urandom_range(0, 1)));
                    push_c(4'd10, 1'($urandom_range(0, 1)));
                end
                default: push_c(4'd11, 1'($urandom_range(0, 1)));
            endcase
        end
    endtask

    // Runs one instruction from the FETCH it is currently in, recording what
    // the DUT shows each cycle and the state/counter just after it ends.
    task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic z,
                         input int wf, input int wm);
        build_seq(o, f, wf, wm);
        obs_st.delete();
        obs_vec.delete();
        obs_ir.delete();
        op = o;
        funct = f;
        zero = z;
        for (int i = 0; i < exp_st.size(); i++) begin
            @(negedge clk);
            mem_ready = exp_rdy[i];
            #1;
            obs_st.push_back(state);
            obs_vec.push_back({memreq, memwrite, iord, irwrite, regwrite, regdst, memtoreg,
                               pcen, illegal, alusrca, alusrcb, alucontrol, pcsrc});
            obs_ir.push_back(instret);
        end
        @(posedge clk);
        #1;
        end_st = state;
        end_ir = instret;
        end_ill = illegal;
        if (is_legal(o, f)) e_instret++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; rst_nh = 1'b1; mem_ready = 1'b1;
        op = OP_LW; funct = 6'd0; zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %0d want 0", instret); end
        checks++; if ({memreq, irwrite, pcen, regwrite, memwrite, illegal} !== 6'b0) begin
            errors++; $display("FAIL reset_forced: got %b want 000000", {memreq, irwrite, pcen, regwrite, memwrite, illegal});
        end
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++; if (memreq !== 1'b1) begin errors++; $display("FAIL post_reset_memreq: got %b want 1", memreq); end
    endtask

    task automatic test_lw();
        logic [31:0] b;
        logic [16:0] v;
        b = e_instret;
        drive(OP_LW, 6'd0, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            v = obs_vec[i];
            checks++; if (obs_st[i] !== 4'(i)) begin errors++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, obs_st[i], i); end
            checks++; if (v[B_REGWRITE] !== (i == 4)) begin errors++; $display("FAIL lw_regwrite[%0d]: got %b want %b", i, v[B_REGWRITE], i == 4); end
        end
        checks++; if (end_st !== 4'd0 || end_ir !== b + 1) begin
            errors++; $display("FAIL lw_end: got state %0d instret %0d want 0 %0d", end_st, end_ir, b + 1);
        end
    endtask

    task automatic test_sw_wait();
        logic [31:0] b;
        logic [16:0] v;
        int n;
        b = e_instret;
        n = 0;
        drive(OP_SW, 6'd0, 1'b0, 0, 3);
        for (int i = 0; i < obs_vec.size(); i++) begin
            v = obs_vec[i];
            if (v[B_MEMWRITE] && v[B_MEMREQ] && v[B_IORD]) n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL sw_write_cycles: got %0d want 4", n); end
        checks++; if (obs_ir[obs_ir.size() - 1] !== b) begin
            errors++; $display("FAIL sw_wait_instret: got %0d want %0d", obs_ir[obs_ir.size() - 1], b);
        end
        checks++; if (end_ir !== b + 1 || end_st !== 4'd0) begin
            errors++; $display("FAIL sw_end: got instret %0d state %0d want %0d 0", end_ir, end_st, b + 1);
        end
    endtask

    task automatic test_beq();
        logic [31:0] b;
        logic [16:0] v;
        for (int zi = 1; zi >= 0; zi--) begin
            b = e_instret;
            drive(OP_BEQ, 6'd0, 1'(zi), 0, 0);
            v = obs_vec[2];
            checks++; if (obs_st[2] !== 4'd8) begin errors++; $display("FAIL beq_state z=%0d: got %0d want 8", zi, obs_st[2]); end
            checks++; if (v[B_PCEN] !== 1'(zi) || v[1:0] !== 2'b01) begin
                errors++; $display("FAIL beq_pc z=%0d: got pcen %b pcsrc %b want %0d 01", zi, v[B_PCEN], v[1:0], zi);
            end
            checks++; if (end_st !== 4'd0 || end_ir !== b + 1) begin
                errors++; $display("FAIL beq_end z=%0d: got state %0d instret %0d want 0 %0d", zi, end_st, end_ir, b + 1);
            end
        end
    endtask

    task automatic test_rtype();
        logic [31:0] b;
        logic [16:0] v;
        b = e_instret;
        drive(OP_RT, 6'b101010, 1'b0, 1, 0);
        v = obs_vec[3];
        checks++; if (obs_st[3] !== 4'd6 || v[4:2] !== 3'b111) begin
            errors++; $display("FAIL slt_exec: got state %0d alu %b want 6 111", obs_st[3], v[4:2]);
        end
        v = obs_vec[4];
        checks++; if (obs_st[4] !== 4'd7 || v[B_REGDST] !== 1'b1 || v[B_REGWRITE] !== 1'b1) begin
            errors++; $display("FAIL slt_wb: got state %0d regdst %b want 7 1", obs_st[4], v[B_REGDST]);
        end
        checks++; if (end_ir !== b + 1) begin errors++; $display("FAIL slt_instret: got %0d want %0d", end_ir, b + 1); end
        b = e_instret;
        drive(OP_RT, 6'b000111, 1'b0, 0, 0);
        v = obs_vec[1];
        checks++; if (obs_st[1] !== 4'd1 || v[B_ILLEGAL] !== 1'b1) begin
            errors++; $display("FAIL badfunct_illegal: got state %0d illegal %b want 1 1", obs_st[1], v[B_ILLEGAL]);
        end
        checks++; if (end_st !== 4'd0 || end_ir !== b || end_ill !== 1'b0) begin
            errors++; $display("FAIL badfunct_end: got state %0d instret %0d ill %b want 0 %0d 0", end_st, end_ir, end_ill, b);
        end
    endtask

    task automatic test_illegal_op();
        logic [31:0] b;
        logic [16:0] v;
        b = e_instret;
        drive(6'b111111, 6'd0, 1'b0, 0, 0);
        v = obs_vec[0];
        checks++; if (v[B_ILLEGAL] !== 1'b0) begin errors++; $display("FAIL badop_fetch_illegal: got %b want 0", v[B_ILLEGAL]); end
        v = obs_vec[1];
        checks++; if (v[B_ILLEGAL] !== 1'b1) begin errors++; $display("FAIL badop_illegal: got %b want 1", v[B_ILLEGAL]); end
        checks++; if (end_st !== 4'd0 || end_ir !== b || end_ill !== 1'b0) begin
            errors++; $display("FAIL badop_end: got state %0d instret %0d ill %b want 0 %0d 0", end_st, end_ir, end_ill, b);
        end
    endtask

    task automatic test_jump();
        logic [31:0] b;
        logic [16:0] v;
        b = e_instret;
        drive(OP_J, 6'd0, 1'b0, 0, 0);
        v = obs_vec[2];
        checks++; if (obs_st[2] !== 4'd11 || v[1:0] !== 2'b10 || v[B_PCEN] !== 1'b1) begin
            errors++; $display("FAIL jump: got state %0d pcsrc %b pcen %b want 11 10 1", obs_st[2], v[1:0], v[B_PCEN]);
        end
        checks++; if (end_st !== 4'd0 || end_ir !== b + 1) begin
            errors++; $display("FAIL jump_end: got state %0d instret %0d want 0 %0d", end_st, end_ir, b + 1);
        end
    endtask

    task automatic test_random();
        logic [5:0] legal_fn[5];
        logic [5:0] o, f;
        logic       z;
        logic [31:0] b;
        legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int n = 0; n < 40; n++) begin
            f = legal_fn[$urandom_range(0, 4)];
            case ($urandom_range(0, 7))
                0: o = OP_LW;
                1: o = OP_SW;
                2: o = OP_RT;
                3: o = OP_BEQ;
                4: o = OP_ADDI;
                5: o = OP_J;
                6: o = 6'($urandom_range(0, 63));
                default: begin o = OP_RT; f = 6'($urandom_range(0, 63)); end
            endcase
            z = 1'($urandom_range(0, 1));
            b = e_instret;
            drive(o, f, z, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            for (int i = 0; i < exp_st.size(); i++) begin
                checks++; if (obs_st[i] !== exp_st[i]) begin
                    errors++; $display("FAIL rnd%0d_state[%0d] op=%b: got %0d want %0d", n, i, o, obs_st[i], exp_st[i]);
                end
                checks++; if (obs_vec[i] !== exp_out(exp_st[i], exp_rdy[i], z, f, is_legal(o, f))) begin
                    errors++; $display("FAIL rnd%0d_ctrl[%0d] op=%b fn=%b: got %b want %b", n, i, o, f,
                                       obs_vec[i], exp_out(exp_st[i], exp_rdy[i], z, f, is_legal(o, f)));
                end
            end
            checks++; if (obs_ir[obs_ir.size() - 1] !== b) begin
                errors++; $display("FAIL rnd%0d_instret_early: got %0d want %0d", n, obs_ir[obs_ir.size() - 1], b);
            end
            checks++; if (end_st !== 4'd0 || end_ir !== e_instret) begin
                errors++; $display("FAIL rnd%0d_end: got state %0d instret %0d want 0 %0d", n, end_st, end_ir, e_instret);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 1'b0;
        op = OP_LW;
        funct = 6'd0;
        mem_ready = 1'b1;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (state == 4'd3) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach_memrd: got %0d want 3", state); end
        reset = 1'b1;
        #1;
        checks++; if (memreq !== 1'b0 || regwrite !== 1'b0) begin
            errors++; $display("FAIL rstmid_forced: got memreq %b regwrite %b want 0 0", memreq, regwrite);
        end
        @(posedge clk);
        #1;
        checks++; if (state !== 4'd0 || instret !== 32'd0) begin
            errors++; $display("FAIL rstmid_after: got state %0d instret %0d want 0 0", state, instret);
        end
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        e_instret = '0;
        #1;
        checks++; if (state !== 4'd0 || regwrite !== 1'b0) begin
            errors++; $display("FAIL rstmid_fetch: got state %0d regwrite %b want 0 0", state, regwrite);
        end
    endtask

    task automatic test_nohandshake();
        logic [3:0] lw_seq[5];
        logic [3:0] j_seq[3];
        lw_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        j_seq = '{4'd0, 4'd1, 4'd11};
        reset = 1'b1;
        @(negedge clk);
        op = OP_LW;
        rst_nh = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++; if (nh_state !== lw_seq[i]) begin
                errors++; $display("FAIL nh_lw_state[%0d]: got %0d want %0d", i, nh_state, lw_seq[i]);
            end
        end
        @(posedge clk);
        #1;
        checks++; if (nh_state !== 4'd0 || nh_instret !== 3'd1) begin
            errors++; $display("FAIL nh_lw_end: got state %0d instret %0d want 0 1", nh_state, nh_instret);
        end
        op = OP_J;
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                #1;
                checks++; if (nh_state !== j_seq[i]) begin
                    errors++; $display("FAIL nh_j%0d_state[%0d]: got %0d want %0d", k, i, nh_state, j_seq[i]);
                end
            end
            if (k == 5) begin
                @(posedge clk);
                #1;
                checks++; if (nh_instret !== 3'd7) begin errors++; $display("FAIL nh_count_max: got %0d want 7", nh_instret); end
            end
        end
        @(posedge clk);
        #1;
        checks++; if (nh_instret !== 3'd0) begin errors++; $display("FAIL nh_wrap: got %0d want 0", nh_instret); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_rtype();
        test_illegal_op();
        test_jump();
        test_random();
        test_reset_mid();
        test_nohandshake();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
